// File: rtl/pwd_enroll_writer_if.sv
// pwd_enroll_writer_if: control, operator input and store-write bundle
// for the password enrollment writer (master = controller/env, slave = writer).
interface pwd_enroll_writer_if #(
   parameter int ADDR_W = 3
);
   logic              start;
   logic [ADDR_W-1:0] user_adrs;
   logic              enter_pulse;
   logic              next_pulse;
   logic [3:0]        pass_in;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W+1:0] mem_addr;
   logic [3:0]        mem_wdata;
   logic              busy;
   logic              confirm_phase;
   logic [1:0]        digit_cnt;
   logic              done;
   logic              error;

   modport master (
      output start, user_adrs, enter_pulse, next_pulse, pass_in, mem_ready,
      input  mem_we, mem_addr, mem_wdata, busy, confirm_phase, digit_cnt,
      input  done, error
   );

   modport slave (
      input  start, user_adrs, enter_pulse, next_pulse, pass_in, mem_ready,
      output mem_we, mem_addr, mem_wdata, busy, confirm_phase, digit_cnt,
      output done, error
   );
endinterface

// File: rtl/pwd_enroll_writer.sv
// pwd_enroll_writer: captures a new 4-digit BCD password, has it re-entered
// for confirmation, then writes the 4 nibbles into the user's store slot.
// Ports: clk; rst (async, active high); bus (slave modport):
//   start/user_adrs      - begin enrollment of a slot (IDLE only)
//   enter_pulse/pass_in  - accept one digit; next_pulse aborts
//   mem_we/mem_addr/mem_wdata/mem_ready - ready-gated store write
//   busy/confirm_phase/digit_cnt/done/error - registered status
module pwd_enroll_writer #(
   parameter int ADDR_W         = 3,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   pwd_enroll_writer_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTER,
      S_CONFIRM,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] adrs, adrs_n;
   logic [1:0]        cnt, cnt_n;
   logic [1:0]        idx, idx_n;
   logic [TW-1:0]     tmr, tmr_n;
   logic              mis, mis_n;
   logic              mis_c;
   logic              dig_we;
   logic              dig_ok;
   logic              tmo;
   logic [3:0]        new_dig [4];

   logic              mem_we_q;
   logic [ADDR_W+1:0] mem_addr_q;
   logic [3:0]        mem_wdata_q;
   logic              busy_q;
   logic              confirm_q;
   logic [1:0]        cnt_q;
   logic              done_q;
   logic              err_q;

   always_comb begin
      state_n = state;
      adrs_n  = adrs;
      cnt_n   = cnt;
      idx_n   = idx;
      tmr_n   = tmr;
      mis_n   = mis;
      mis_c   = mis;
      dig_we  = 1'b0;
      dig_ok  = bus.enter_pulse && (bus.pass_in <= 4'd9);
      tmo     = (tmr == TMAX);

      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_n = S_ENTER;
               adrs_n  = bus.user_adrs;
               cnt_n   = 2'd0;
               tmr_n   = '0;
            end
         end
         S_ENTER: begin
            // Abort beats a coincident digit; a digit beats the timer.
            if (bus.next_pulse) begin
               state_n = S_ERR;
            end else if (dig_ok) begin
               dig_we = 1'b1;
               cnt_n  = cnt + 2'd1;
               tmr_n  = '0;
               if (cnt == 2'd3) begin
                  state_n = S_CONFIRM;
                  cnt_n   = 2'd0;
                  mis_n   = 1'b0;
               end
            end else if (tmo) begin
               state_n = S_ERR;
            end else begin
               tmr_n = tmr + TW'(1);
            end
         end
         S_CONFIRM: begin
            if (bus.next_pulse) begin
               state_n = S_ERR;
            end else if (dig_ok) begin
               // Mismatch is sticky so all 4 digits are always taken.
               mis_c = mis | (bus.pass_in != new_dig[cnt]);
               mis_n = mis_c;
               cnt_n = cnt + 2'd1;
               tmr_n = '0;
               if (cnt == 2'd3) begin
                  cnt_n   = 2'd0;
                  idx_n   = 2'd0;
                  state_n = mis_c ? S_ERR : S_WRITE;
               end
            end else if (tmo) begin
               state_n = S_ERR;
            end else begin
               tmr_n = tmr + TW'(1);
            end
         end
         S_WRITE: begin
            if (bus.mem_ready) begin
               idx_n = idx + 2'd1;
               if (idx == 2'd3) begin
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: state_n = S_IDLE;
         S_ERR:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         adrs  <= '0;
         cnt   <= 2'd0;
         idx   <= 2'd0;
         tmr   <= '0;
         mis   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            new_dig[i] <= 4'd0;
         end
      end else begin
         state <= state_n;
         adrs  <= adrs_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         tmr   <= tmr_n;
         mis   <= mis_n;
         if (dig_we) begin
            new_dig[cnt] <= bus.pass_in;
         end
      end
   end

   // Status/write outputs are registered from the next-state values so they
   // change exactly one edge after the causing input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 4'd0;
         busy_q      <= 1'b0;
         confirm_q   <= 1'b0;
         cnt_q       <= 2'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q    <= (state_n == S_WRITE);
         mem_addr_q  <= (state_n == S_WRITE) ? {adrs_n, idx_n} : '0;
         mem_wdata_q <= (state_n == S_WRITE) ? new_dig[idx_n] : 4'd0;
         busy_q      <= (state_n != S_IDLE);
         confirm_q   <= (state_n == S_CONFIRM);
         cnt_q       <= (state_n == S_ENTER || state_n == S_CONFIRM)
                        ? cnt_n : 2'd0;
         done_q      <= (state_n == S_DONE);
         err_q       <= (state_n == S_ERR);
      end
   end

   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.busy          = busy_q;
   assign bus.confirm_phase = confirm_q;
   assign bus.digit_cnt     = cnt_q;
   assign bus.done          = done_q;
   assign bus.error         = err_q;

endmodule

// File: tb/tb_pwd_enroll_writer.sv
// tb_pwd_enroll_writer: directed bench for pwd_enroll_writer with a
// write scoreboard popped on every accepted store write.
module tb_pwd_enroll_writer;

   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errs   = 0;
   int checks = 0;
   int we_cycles = 0;

   logic [9:0] exp_q [$];

   pwd_enroll_writer_if #(.ADDR_W(AW)) bus ();

   pwd_enroll_writer #(
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted write must match the oldest expectation.
   always @(negedge clk) begin
      logic [9:0] e;
      #1;
      if (!rst && bus.mem_we) begin
         we_cycles++;
         if (bus.mem_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h0;
            checks++;
            assert ({1'b1, bus.mem_addr, bus.mem_wdata} === e) else begin
               errs++;
               $error("FAIL write: got %0h expected %0h",
                      {1'b1, bus.mem_addr, bus.mem_wdata}, e);
            end
         end
      end
   end

   task automatic do_start(input logic [AW-1:0] a);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.user_adrs = a;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic digit(input logic [3:0] d);
      @(negedge clk);
      bus.pass_in     = d;
      bus.enter_pulse = 1'b1;
      @(negedge clk);
      bus.enter_pulse = 1'b0;
   endtask

   task automatic seq4(input logic [15:0] ds);
      for (int i = 3; i >= 0; i--) begin
         digit(ds[i*4 +: 4]);
      end
   endtask

   task automatic push4(input logic [AW-1:0] a, input logic [15:0] ds);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b1, a, 2'(i), ds[(3-i)*4 +: 4]});
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!bus.done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.done, 1);
   endtask

   initial begin
      int n;
      int wc;
      logic [4:0] a0;
      logic [3:0] d0;
      logic       stable;

      bus.start       = 1'b0;
      bus.user_adrs   = '0;
      bus.enter_pulse = 1'b0;
      bus.next_pulse  = 1'b0;
      bus.pass_in     = 4'd0;
      bus.mem_ready   = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_outs", {bus.mem_we, bus.busy, bus.done, bus.error,
                       bus.confirm_phase, bus.digit_cnt}, 0);
      chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
      rst = 1'b0;

      // Happy path
      do_start(3'd5);
      chk("hp_busy", bus.busy, 1);
      digit(4'd3);
      digit(4'd1);
      chk("hp_cnt2", bus.digit_cnt, 2);
      digit(4'd4);
      digit(4'd1);
      chk("hp_confirm", {bus.confirm_phase, bus.digit_cnt}, 3'b100);
      push4(3'd5, 16'h3141);
      wc = we_cycles;
      seq4(16'h3141);
      wait_done("hp_done");
      chk("hp_we_cycles", we_cycles - wc, 4);
      chk("hp_busy_done", bus.busy, 1);
      @(negedge clk);
      chk("hp_idle", {bus.busy, bus.done}, 0);

      // Confirm mismatch
      do_start(3'd2);
      seq4(16'h2709);
      wc = we_cycles;
      seq4(16'h2708);
      chk("mm_error", {bus.error, bus.mem_we}, 2'b10);
      @(negedge clk);
      chk("mm_idle", {bus.error, bus.busy}, 0);
      chk("mm_no_we", we_cycles - wc, 0);

      // Invalid digit ignored
      do_start(3'd1);
      digit(4'd5);
      digit(4'hA);
      chk("inv_cnt", bus.digit_cnt, 1);
      digit(4'd6);
      chk("inv_cnt2", bus.digit_cnt, 2);
      digit(4'd2);
      digit(4'd9);
      push4(3'd1, 16'h5629);
      seq4(16'h5629);
      wait_done("inv_done");
      @(negedge clk);

      // Stalled memory on idx 1
      do_start(3'd7);
      seq4(16'h8025);
      push4(3'd7, 16'h8025);
      wc = we_cycles;
      seq4(16'h8025);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      a0 = bus.mem_addr;
      d0 = bus.mem_wdata;
      chk("st_addr", {a0, d0}, {5'h1D, 4'd0});
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!bus.mem_we || bus.mem_addr !== a0 || bus.mem_wdata !== d0)
            stable = 1'b0;
      end
      chk("st_stable", stable, 1);
      bus.mem_ready = 1'b1;
      wait_done("st_done");
      chk("st_we_cycles", we_cycles - wc, 9);
      @(negedge clk);

      // Timeout after 2 digits
      do_start(3'd4);
      digit(4'd1);
      digit(4'd2);
      n = 0;
      while (!bus.error && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", n, 20);
      @(negedge clk);
      chk("to_idle", bus.busy, 0);

      // Abort coincident with enter in CONFIRM
      do_start(3'd3);
      seq4(16'h1234);
      wc = we_cycles;
      digit(4'd1);
      @(negedge clk);
      bus.pass_in     = 4'd2;
      bus.enter_pulse = 1'b1;
      bus.next_pulse  = 1'b1;
      @(negedge clk);
      bus.enter_pulse = 1'b0;
      bus.next_pulse  = 1'b0;
      chk("ab_error", {bus.error, bus.confirm_phase}, 2'b10);
      @(negedge clk);
      chk("ab_no_we", we_cycles - wc, 0);

      // Reset mid-write at idx 2
      do_start(3'd6);
      seq4(16'h9876);
      exp_q.push_back({1'b1, 3'd6, 2'd0, 4'd9});
      exp_q.push_back({1'b1, 3'd6, 2'd1, 4'd8});
      seq4(16'h9876);
      @(negedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("rw_idx2", {bus.mem_we, bus.mem_addr}, {1'b1, 5'h1A});
      #2;
      rst = 1'b1;
      #1;
      chk("rw_async", {bus.mem_we, bus.busy, bus.done}, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      chk("rw_idle", bus.busy, 0);
      do_start(3'd4);
      chk("rw_restart", {bus.busy, bus.digit_cnt}, 3'b100);
      @(negedge clk);
      bus.next_pulse = 1'b1;
      @(negedge clk);
      bus.next_pulse = 1'b0;
      chk("rw_abort", bus.error, 1);
      @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
